awg_chan: RTL and testbench

Parametrised single-channel DDS waveform generator that drives one DAC channel with the same DA_DATA/DA_CLK/DA_WR signalling as the existing front end. A PHASE_W-bit phase accumulator replaces the free-running sample counter. Configuration passes through a valid/ready shadow register and is applied only at a phase wrap, so mode and frequency changes are glitch-free. It adds duty-controlled square, an optional noise mode, phase offset, a sync pulse and a fixed-latency output pipeline.

---
 rtl/awg_chan_if.sv | 23 ++
 rtl/awg_chan.sv | 254 +++++++++++++++++++++++++
 tb/tb_awg_chan.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/awg_chan_if.sv
// Configuration channel of awg_chan: valid/ready handshake carrying one complete
// waveform setting (mode, tuning word, start phase, duty threshold, gain).
interface awg_chan_if #(
    parameter int PHASE_W = 32
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         cfg_mode;
    logic [PHASE_W-1:0] cfg_ftw;
    logic [PHASE_W-1:0] cfg_phase;
    logic [PHASE_W-1:0] cfg_duty;
    logic [7:0]         cfg_amp;

    modport master (
        output cfg_valid, cfg_mode, cfg_ftw, cfg_phase, cfg_duty, cfg_amp,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_ftw, cfg_phase, cfg_duty, cfg_amp,
        output cfg_ready
    );
endinterface

// File: rtl/awg_chan.sv
// Single-channel DDS waveform generator: phase accumulator, wrap-synchronous config
// apply, 3-stage output pipeline. Define AWG_NOISE_EN to build the LFSR noise mode.
module awg_chan #(
    parameter int DAC_W    = 14,
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 8,
    parameter     SIN_FILE = "sin_q.hex"
) (
    input  logic             clk,
    input  logic             rst_n,
    awg_chan_if.slave        cfg,
    output logic [2:0]       active_mode,
    output logic             sync_out,
    output logic [DAC_W-1:0] DA_DATA,
    output logic             DA_CLK,
    output logic             DA_WR
);
    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_SAW   = 3'd1,
        MODE_TRI   = 3'd2,
        MODE_SQR   = 3'd3,
        MODE_SIN   = 3'd4,
        MODE_NOISE = 3'd5,
        MODE_RSV6  = 3'd6,
        MODE_RSV7  = 3'd7
    } awg_mode_e;

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_e;

    localparam logic [DAC_W-1:0] HALF = {1'b1, {(DAC_W-1){1'b0}}};
    // pi/2 in Q60, used only to build the quarter-wave table at elaboration
    localparam logic signed [127:0] PI_HALF_Q60 = 128'sh1921_FB54_442D_1846;

    if (DAC_W < 8 || PHASE_W < DAC_W + 2 || LUT_AW > PHASE_W - 2 || $bits(SIN_FILE) == 0)
    begin : g_param_check
        $error("awg_chan: unsupported parameterisation");
    end

    // The table holds round((2^(DAC_W-1)-1)*sin(pi/2*(i+0.5)/2^LUT_AW)), the same
    // image SIN_FILE carries, evaluated here by a Taylor series so no file is needed.
    function automatic logic [DAC_W-2:0] sin_entry(input int unsigned i);
        logic signed [127:0] x, x2, term, sum, den, scaled;
        x    = (PI_HALF_Q60 * $signed({96'd0, 32'(2 * i + 1)})) >>> (LUT_AW + 1);
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int unsigned k = 1; k <= 12; k++) begin
            den  = $signed({96'd0, 32'((2 * k) * (2 * k + 1))});
            term = -(((term * x2) >>> 60) / den);
            sum  = sum + term;
        end
        scaled = sum * $signed({96'd0, 32'((2 ** (DAC_W - 1)) - 1)}) + (128'sd1 <<< 59);
        return (DAC_W-1)'(scaled >>> 60);
    endfunction

    function automatic logic mode_is_off(input awg_mode_e m);
        case (m)
            MODE_SAW, MODE_TRI, MODE_SQR, MODE_SIN: return 1'b0;
`ifdef AWG_NOISE_EN
            MODE_NOISE: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    logic [DAC_W-2:0] lut_rom [2**LUT_AW];
    for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_lut
        localparam logic [DAC_W-2:0] ENTRY = sin_entry(gi);
        assign lut_rom[gi] = ENTRY;
    end

    cfg_state_e         state_q, state_d;
    logic               accept, apply, apply_cond, carry;
    logic [PHASE_W-1:0] acc_q, acc_d, acc_inc;
    logic               wrap_q, wrap_d;
    awg_mode_e          sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [PHASE_W-1:0] sh_ftw_q, sh_ftw_d, act_ftw_q, act_ftw_d;
    logic [PHASE_W-1:0] sh_phase_q, sh_phase_d;
    logic [PHASE_W-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
    logic [7:0]         sh_amp_q, sh_amp_d, act_amp_q, act_amp_d;

    logic [DAC_W-1:0]   t, tri_u, wave1_q, wave1_d, wave2;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  lut_idx;
    logic [DAC_W-2:0]   lut_q, lut_d;
    logic               sin1_q, sin1_d, neg1_q, neg1_d, sync1_q, sync1_d;
    logic [7:0]         amp1_q, amp1_d;
    awg_mode_e          mode1_q, mode1_d, mode2_q, mode2_d, mode3_q, mode3_d;
    logic [DAC_W-1:0]   scl_q, scl_d, da_q, da_d;
    logic               sync2_q, sync2_d, sync3_q, sync3_d;

`ifdef AWG_NOISE_EN
    logic [31:0] lfsr_q, lfsr_d;

    // Galois form of x^32+x^22+x^2+x+1
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 32'd1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        {carry, acc_inc} = {1'b0, acc_q} + {1'b0, act_ftw_q};
        apply_cond       = carry | mode_is_off(act_mode_q) | (act_ftw_q == '0);
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        apply   = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                if (cfg.cfg_valid) begin
                    accept  = 1'b1;
                    state_d = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (apply_cond) begin
                    apply   = 1'b1;
                    state_d = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    assign cfg.cfg_ready = (state_q == CFG_IDLE);

    always_comb begin
        sh_mode_d  = sh_mode_q;
        sh_ftw_d   = sh_ftw_q;
        sh_phase_d = sh_phase_q;
        sh_duty_d  = sh_duty_q;
        sh_amp_d   = sh_amp_q;
        if (accept) begin
            sh_mode_d  = awg_mode_e'(cfg.cfg_mode);
            sh_ftw_d   = cfg.cfg_ftw;
            sh_phase_d = cfg.cfg_phase;
            sh_duty_d  = cfg.cfg_duty;
            sh_amp_d   = cfg.cfg_amp;
        end
        act_mode_d = apply ? sh_mode_q : act_mode_q;
        act_ftw_d  = apply ? sh_ftw_q  : act_ftw_q;
        act_duty_d = apply ? sh_duty_q : act_duty_q;
        act_amp_d  = apply ? sh_amp_q  : act_amp_q;
        // the load value replaces this cycle's increment; the carry still marks the wrap
        acc_d      = apply ? sh_phase_q : acc_inc;
        wrap_d     = carry;
    end

    always_comb begin
        t       = acc_q[PHASE_W-1 -: DAC_W];
        tri_u   = {t[DAC_W-2:0], 1'b0};
        quad    = acc_q[PHASE_W-1 -: 2];
        lut_idx = quad[0] ? ~acc_q[PHASE_W-3 -: LUT_AW] : acc_q[PHASE_W-3 -: LUT_AW];
        wave1_d = '0;
        case (act_mode_q)
            MODE_SAW:   wave1_d = t;
            MODE_TRI:   wave1_d = acc_q[PHASE_W-1] ? ~tri_u : tri_u;
            MODE_SQR:   wave1_d = (acc_q < act_duty_q) ? '1 : '0;
`ifdef AWG_NOISE_EN
            MODE_NOISE: wave1_d = lfsr_q[DAC_W-1:0];
`endif
            default:    wave1_d = '0;
        endcase
        lut_d   = lut_rom[lut_idx];
        sin1_d  = (act_mode_q == MODE_SIN);
        neg1_d  = quad[1];
        amp1_d  = act_amp_q;
        sync1_d = wrap_q;
        mode1_d = act_mode_q;
    end

    always_comb begin
        wave2   = sin1_q ? (neg1_q ? HALF - {1'b0, lut_q} : HALF + {1'b0, lut_q}) : wave1_q;
        scl_d   = DAC_W'(({9'd0, wave2} * {{DAC_W{1'b0}}, ({1'b0, amp1_q} + 9'd1)}) >> 8);
        sync2_d = sync1_q;
        mode2_d = mode1_q;
        da_d    = scl_q;
        sync3_d = sync2_q;
        mode3_d = mode2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CFG_IDLE;
            acc_q      <= '0;
            wrap_q     <= 1'b0;
            sh_mode_q  <= MODE_OFF;
            sh_ftw_q   <= '0;
            sh_phase_q <= '0;
            sh_duty_q  <= '0;
            sh_amp_q   <= '0;
            act_mode_q <= MODE_OFF;
            act_ftw_q  <= '0;
            act_duty_q <= '0;
            act_amp_q  <= '0;
            wave1_q    <= '0;
            lut_q      <= '0;
            sin1_q     <= 1'b0;
            neg1_q     <= 1'b0;
            amp1_q     <= '0;
            sync1_q    <= 1'b0;
            mode1_q    <= MODE_OFF;
            scl_q      <= '0;
            sync2_q    <= 1'b0;
            mode2_q    <= MODE_OFF;
            da_q       <= '0;
            sync3_q    <= 1'b0;
            mode3_q    <= MODE_OFF;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            wrap_q     <= wrap_d;
            sh_mode_q  <= sh_mode_d;
            sh_ftw_q   <= sh_ftw_d;
            sh_phase_q <= sh_phase_d;
            sh_duty_q  <= sh_duty_d;
            sh_amp_q   <= sh_amp_d;
            act_mode_q <= act_mode_d;
            act_ftw_q  <= act_ftw_d;
            act_duty_q <= act_duty_d;
            act_amp_q  <= act_amp_d;
            wave1_q    <= wave1_d;
            lut_q      <= lut_d;
            sin1_q     <= sin1_d;
            neg1_q     <= neg1_d;
            amp1_q     <= amp1_d;
            sync1_q    <= sync1_d;
            mode1_q    <= mode1_d;
            scl_q      <= scl_d;
            sync2_q    <= sync2_d;
            mode2_q    <= mode2_d;
            da_q       <= da_d;
            sync3_q    <= sync3_d;
            mode3_q    <= mode3_d;
        end
    end

    assign DA_DATA     = da_q;
    assign sync_out    = sync3_q;
    assign active_mode = mode3_q;
    assign DA_CLK      = clk;
    assign DA_WR       = ~clk;
endmodule

// File: tb/tb_awg_chan.sv
// Bench for awg_chan: directed scenarios plus randomized configs, compared every cycle
// against a behavioural model built from phase arithmetic and real-valued sine.
module tb_awg_chan;
    localparam int DAC_W   = 14;
    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 8;
    localparam real PI     = 3.14159265358979323846;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       active_mode;
    logic             sync_out;
    logic [DAC_W-1:0] da_data;
    logic             da_clk, da_wr;

    awg_chan_if #(.PHASE_W(PHASE_W)) cfg_if ();

    awg_chan #(
        .DAC_W    (DAC_W),
        .PHASE_W  (PHASE_W),
        .LUT_AW   (LUT_AW),
        .SIN_FILE ("sin_q.hex")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if.slave),
        .active_mode (active_mode),
        .sync_out    (sync_out),
        .DA_DATA     (da_data),
        .DA_CLK      (da_clk),
        .DA_WR       (da_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int da;
        bit sync;
        int mode;
    } smp_t;

    smp_t            pipe[$];
    longint unsigned m_acc, m_ftw, m_duty, sh_ftw, sh_phase, sh_duty;
    int              m_mode, m_amp, sh_mode, sh_amp;
    bit              m_wrap, m_pend;
    bit [31:0]       m_lfsr;

    function automatic bit noise_on();
`ifdef AWG_NOISE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_off(input int m);
        return !((m >= 1 && m <= 4) || (m == 5 && noise_on()));
    endfunction

    function automatic int sin_lut(input int idx);
        real v;
        v = (real'(1 << (DAC_W - 1)) - 1.0) *
            $sin(PI / 2.0 * (real'(idx) + 0.5) / real'(1 << LUT_AW));
        return $rtoi(v + 0.5);
    endfunction

    function automatic int wave_of(input int mode, input longint unsigned p,
                                   input longint unsigned duty, input bit [31:0] lfsr);
        longint unsigned full, quarter, t, u, q, idx, mx;
        full    = 64'd1 << PHASE_W;
        quarter = full / 4;
        mx      = (64'd1 << DAC_W) - 1;
        t       = p / (64'd1 << (PHASE_W - DAC_W));
        case (mode)
            1: return int'(t);
            2: begin
                u = (2 * t) % (mx + 1);
                return int'((p < full / 2) ? u : mx - u);
            end
            3: return int'((p < duty) ? mx : 0);
            4: begin
                q   = p / quarter;
                idx = (p / (quarter >> LUT_AW)) % (64'd1 << LUT_AW);
                if (q % 2 == 1) idx = (64'd1 << LUT_AW) - 1 - idx;
                return (q < 2) ? (1 << (DAC_W - 1)) + sin_lut(int'(idx))
                               : (1 << (DAC_W - 1)) - sin_lut(int'(idx));
            end
            5: return noise_on() ? int'(lfsr % (32'd1 << DAC_W)) : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        smp_t z;
        z = '{da: 0, sync: 1'b0, mode: 0};
        m_acc = 0; m_ftw = 0; m_duty = 0; m_mode = 0; m_amp = 0;
        sh_ftw = 0; sh_phase = 0; sh_duty = 0; sh_mode = 0; sh_amp = 0;
        m_wrap = 1'b0; m_pend = 1'b0; m_lfsr = 32'd1;
        pipe.delete();
        repeat (3) pipe.push_back(z);
    endtask

    task automatic model_edge();
        smp_t            s;
        longint unsigned sum;
        bit              carry, acc_now, apply_now;
        s.da   = (wave_of(m_mode, m_acc, m_duty, m_lfsr) * (m_amp + 1)) / 256;
        s.sync = m_wrap;
        s.mode = m_mode;
        pipe.push_back(s);
        void'(pipe.pop_front());

        sum       = m_acc + m_ftw;
        carry     = (sum >= (64'd1 << PHASE_W));
        acc_now   = cfg_if.cfg_valid && !m_pend;
        apply_now = m_pend && (carry || is_off(m_mode) || m_ftw == 0);
        if (apply_now) begin
            m_mode = sh_mode; m_ftw = sh_ftw; m_duty = sh_duty; m_amp = sh_amp;
            m_acc  = sh_phase;
            m_pend = 1'b0;
        end else begin
            m_acc = sum % (64'd1 << PHASE_W);
        end
        m_wrap = carry;
        if (acc_now) begin
            sh_mode = int'(cfg_if.cfg_mode); sh_ftw = cfg_if.cfg_ftw;
            sh_phase = cfg_if.cfg_phase; sh_duty = cfg_if.cfg_duty; sh_amp = int'(cfg_if.cfg_amp);
            m_pend = 1'b1;
        end
        m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic compare_outputs(input string ph);
        check({ph, "/da_data"},     64'(da_data),          64'(pipe[0].da));
        check({ph, "/sync_out"},    64'(sync_out),         64'(pipe[0].sync));
        check({ph, "/active_mode"}, 64'(active_mode),      64'(pipe[0].mode));
        check({ph, "/cfg_ready"},   64'(cfg_if.cfg_ready), 64'(!m_pend));
        check({ph, "/da_clk"},      64'(da_clk),           64'(clk));
        check({ph, "/da_wr"},       64'(da_wr),            64'(!clk));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_outputs(ph);
    endtask

    task automatic run(input int n, input string ph);
        repeat (n) tick(ph);
    endtask

    task automatic offer(input logic [2:0] mode, input logic [31:0] ftw, input logic [31:0] phase,
                         input logic [31:0] duty, input logic [7:0] amp, input string ph);
        bit accepted;
        accepted = 1'b0;
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_ftw   = ftw;
        cfg_if.cfg_phase = phase;
        cfg_if.cfg_duty  = duty;
        cfg_if.cfg_amp   = amp;
        cfg_if.cfg_valid = 1'b1;
        for (int g = 0; g < 2000 && !accepted; g++) begin
            accepted = !m_pend;
            tick(ph);
        end
        cfg_if.cfg_valid = 1'b0;
        if (!accepted) check({ph, "/accept_bound"}, 64'(m_pend), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int changes;
        logic [DAC_W-1:0] prev;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_ftw   = '0;
        cfg_if.cfg_phase = '0;
        cfg_if.cfg_duty  = '0;
        cfg_if.cfg_amp   = '0;
        model_reset();
        run(4, "reset");
        rst_n = 1'b1;
        run(5, "idle");

        offer(3'd1, 32'h0100_0000, 32'h0, 32'h0, 8'd255, "saw");
        run(270, "saw");

        offer(3'd2, 32'h4000_0000, 32'h0, 32'h0, 8'd255, "tri");
        run(20, "tri");

        offer(3'd3, 32'h1000_0000, 32'h0, 32'h8000_0000, 8'd127, "sqr");
        run(37, "sqr");
        offer(3'd4, 32'h0400_0000, 32'h0, 32'h0, 8'd255, "sqr2sin");
        run(150, "sin");

        // config left pending when reset hits between clock edges
        offer(3'd1, 32'h0100_0000, 32'h0, 32'h0, 8'd255, "rst_pend");
        run(3, "rst_pend");
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_outputs("async_rst");
        run(3, "in_rst");
        rst_n = 1'b1;
        run(100, "post_rst");

        offer(3'd5, 32'h0, 32'h0, 32'h0, 8'd255, "noise");
        run(4, "noise");
        changes = 0;
        prev    = da_data;
        for (int i = 0; i < 40; i++) begin
            tick("noise");
            if (da_data != prev) changes++;
            prev = da_data;
        end
`ifdef AWG_NOISE_EN
        check("noise_varies", 64'(changes > 0), 64'd1);
`else
        check("noise_silent", 64'(changes), 64'd0);
`endif

        for (int r = 0; r < 40; r++) begin
            logic [31:0] ftw;
            ftw = ($urandom_range(0, 9) == 0) ? 32'h0
                : {8'($urandom_range(1, 255)), 24'($urandom)};
            run($urandom_range(0, 4), "rnd_gap");
            offer(3'($urandom_range(0, 7)), ftw, $urandom, $urandom,
                  8'($urandom_range(0, 255)), "rnd_offer");
            run($urandom_range(0, 200), "rnd_run");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
